// File: rtl/bp_sacc_dma_target_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_sacc_dma_target_pkg                                         |
// | Purpose : Shared types for the streaming-accelerator DMA target:         |
// |           BedRock CCE memory header layout, message types, the target    |
// |           FSM state enum, accelerator CSR indices, and a size helper.    |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bp_sacc_dma_target_pkg;

   localparam int paddr_width_p           = 40;
   localparam int cce_block_width_p       = 512;
   localparam int bedrock_payload_width_p = 16;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   // size encodes 2^size bytes (0:1B .. 7:128B)
   typedef struct packed {
      logic [bedrock_payload_width_p-1:0] payload;
      logic [2:0]                         size;
      logic [paddr_width_p-1:0]           addr;
      logic [3:0]                         subop;
      bp_bedrock_mem_type_e               msg_type;
   } bp_bedrock_cce_mem_header_s;

   localparam int cce_mem_header_width_lp = $bits(bp_bedrock_cce_mem_header_s);

   typedef enum logic [1:0] {
      e_idle   = 2'd0,
      e_rd_cap = 2'd1,
      e_resp   = 2'd2
   } bp_sacc_dma_target_state_e;

   // Streaming-accelerator CSR indices
   localparam logic [7:0] accel_csr_input_ptr_idx  = 8'd0;
   localparam logic [7:0] accel_csr_input_len_idx  = 8'd1;
   localparam logic [7:0] accel_csr_output_ptr_idx = 8'd2;
   localparam logic [7:0] accel_csr_start_idx      = 8'd3;
   localparam logic [7:0] accel_csr_done_idx       = 8'd4;

   // Scratchpad is 64 bits wide, so anything wider than 8 bytes acts as 8.
   function automatic logic [1:0] bp_sacc_size_clamp(input logic [2:0] size);
      return (size > 3'd3) ? 2'd3 : size[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sacc_dma_target_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bsg_mem_1rw_sync_mask_write_byte                               |
// | Purpose : Single-port synchronous SRAM with per-byte write mask.         |
// |           Read data appears the cycle after a read is issued and holds   |
// |           until the next read. Contents are never reset.                 |
// | Ports   : clk_i, v_i (access), w_i (1=write), addr_i, data_i,            |
// |           write_mask_i (one bit per byte), data_o (registered read)      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bsg_mem_1rw_sync_mask_write_byte #(
   parameter int  data_width_p  = 64,
   parameter int  els_p         = 4096,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int mask_width_lp = data_width_p / 8
) (
   input  logic                     clk_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [data_width_p-1:0]  data_i,
   input  logic [mask_width_lp-1:0] write_mask_i,
   output logic [data_width_p-1:0]  data_o
);

   logic [data_width_p-1:0] mem_q [els_p];
   logic [data_width_p-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (v_i & w_i) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (write_mask_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
      if (v_i & ~w_i) begin
         data_q <= mem_q[addr_i];
      end
   end

   assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/bp_sacc_dma_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_sacc_dma_target                                             |
// | Purpose : CCE-IO responder for uncached DMA from streaming-accelerator   |
// |           tiles. Serves uc_wr / uc_rd against a 64-bit scratchpad, one   |
// |           response per command, counts writes, flags bad requests.       |
// | Ports   : clk_i, reset_i (async, active-high)                            |
// |           io_cmd_header_i/data_i/v_i, io_cmd_ready_o : command in        |
// |           io_resp_header_o/data_o/v_o, io_resp_yumi_i : response out     |
// |           wr_count_o : saturating uc_wr count; err_o : sticky error      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bp_sacc_dma_target
   import bp_sacc_dma_target_pkg::*;
#(
   parameter int  els_p     = 4096,
   localparam int lg_els_lp = $clog2(els_p)
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [cce_mem_header_width_lp-1:0] io_cmd_header_i,
   input  logic [cce_block_width_p-1:0]       io_cmd_data_i,
   input  logic                               io_cmd_v_i,
   output logic                               io_cmd_ready_o,
   output logic [cce_mem_header_width_lp-1:0] io_resp_header_o,
   output logic [cce_block_width_p-1:0]       io_resp_data_o,
   output logic                               io_resp_v_o,
   input  logic                               io_resp_yumi_i,
   output logic [31:0]                        wr_count_o,
   output logic                               err_o
);

   bp_bedrock_cce_mem_header_s cmd_hdr;
   assign cmd_hdr = io_cmd_header_i;

   bp_sacc_dma_target_state_e  state_q, state_d;
   bp_bedrock_cce_mem_header_s hdr_q, hdr_d;
   logic [63:0]                data_q, data_d;
   logic [31:0]                wr_count_q, wr_count_d;
   logic                       err_q, err_d;

   // Command decode: aligned means the offset is a multiple of the access size
   logic [1:0] cmd_sz;
   logic [2:0] cmd_off;
   logic [3:0] cmd_span;
   logic       cmd_aligned;
   logic [7:0] cmd_mask;
   logic [63:0] cmd_wdata;

   assign cmd_sz      = bp_sacc_size_clamp(cmd_hdr.size);
   assign cmd_off     = cmd_hdr.addr[2:0];
   assign cmd_span    = 4'd1 << cmd_sz;
   assign cmd_aligned = (cmd_off & 3'(cmd_span - 4'd1)) == 3'd0;
   assign cmd_mask    = 8'((9'd1 << cmd_span) - 9'd1) << cmd_off;
   assign cmd_wdata   = io_cmd_data_i[63:0] << {cmd_off, 3'b000};

   // Read return path, driven from the latched header
   logic [1:0]  rsp_sz;
   logic [2:0]  rsp_off;
   logic        rsp_aligned;
   logic [63:0] mem_data_lo;
   logic [63:0] rd_shift;
   logic [63:0] rd_field;

   assign rsp_sz      = bp_sacc_size_clamp(hdr_q.size);
   assign rsp_off     = hdr_q.addr[2:0];
   assign rsp_aligned = (rsp_off & 3'((4'd1 << rsp_sz) - 4'd1)) == 3'd0;
   assign rd_shift    = mem_data_lo >> {rsp_off, 3'b000};

   always_comb begin
      rd_field = rd_shift;
      case (rsp_sz)
         2'd0:    rd_field = {8{rd_shift[7:0]}};
         2'd1:    rd_field = {4{rd_shift[15:0]}};
         2'd2:    rd_field = {2{rd_shift[31:0]}};
         default: rd_field = rd_shift;
      endcase
   end

   logic mem_v, mem_w;

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      data_d     = data_q;
      wr_count_d = wr_count_q;
      err_d      = err_q;
      mem_v      = 1'b0;
      mem_w      = 1'b0;

      case (state_q)
         e_idle: begin
            if (io_cmd_v_i) begin
               hdr_d  = cmd_hdr;
               data_d = '0;
               case (cmd_hdr.msg_type)
                  e_bedrock_mem_uc_wr: begin
                     // Misaligned writes are dropped but still counted
                     mem_v = cmd_aligned;
                     mem_w = 1'b1;
                     if (wr_count_q != 32'hFFFF_FFFF) begin
                        wr_count_d = wr_count_q + 32'd1;
                     end
                     if (!cmd_aligned) err_d = 1'b1;
                     state_d = e_resp;
                  end
                  e_bedrock_mem_uc_rd: begin
                     mem_v = 1'b1;
                     if (!cmd_aligned) err_d = 1'b1;
                     state_d = e_rd_cap;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = e_resp;
                  end
               endcase
            end
         end
         e_rd_cap: begin
            data_d  = rsp_aligned ? rd_field : 64'd0;
            state_d = e_resp;
         end
         e_resp: begin
            if (io_resp_yumi_i) state_d = e_idle;
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= e_idle;
         hdr_q      <= '0;
         data_q     <= '0;
         wr_count_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         data_q     <= data_d;
         wr_count_q <= wr_count_d;
         err_q      <= err_d;
      end
   end

   bsg_mem_1rw_sync_mask_write_byte #(
      .data_width_p (64),
      .els_p        (els_p)
   ) u_mem (
      .clk_i        (clk_i),
      .v_i          (mem_v),
      .w_i          (mem_w),
      .addr_i       (cmd_hdr.addr[3 +: lg_els_lp]),
      .data_i       (cmd_wdata),
      .write_mask_i (cmd_mask),
      .data_o       (mem_data_lo)
   );

   assign io_cmd_ready_o   = (state_q == e_idle);
   assign io_resp_v_o      = (state_q == e_resp);
   assign io_resp_header_o = hdr_q;
   assign io_resp_data_o   = {(cce_block_width_p / 64){data_q}};
   assign wr_count_o       = wr_count_q;
   assign err_o            = err_q;

   // Upper data lanes and aliased address bits are intentionally ignored
   logic unused_bits;
   assign unused_bits = ^{io_cmd_data_i[cce_block_width_p-1:64],
                          cmd_hdr.addr[paddr_width_p-1:3+lg_els_lp]};

endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_dma_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bp_sacc_dma_target                                          |
// | Purpose : Self-checking bench for bp_sacc_dma_target. A byte-addressed   |
// |           reference memory predicts read data, write count and error.   |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_bp_sacc_dma_target;
   import bp_sacc_dma_target_pkg::*;

   localparam int MEM_BYTES = 4096 * 8;

   logic                               clk;
   logic                               reset_i;
   logic [cce_mem_header_width_lp-1:0] io_cmd_header_i;
   logic [cce_block_width_p-1:0]       io_cmd_data_i;
   logic                               io_cmd_v_i;
   logic                               io_cmd_ready_o;
   logic [cce_mem_header_width_lp-1:0] io_resp_header_o;
   logic [cce_block_width_p-1:0]       io_resp_data_o;
   logic                               io_resp_v_o;
   logic                               io_resp_yumi_i;
   logic [31:0]                        wr_count_o;
   logic                               err_o;

   bp_sacc_dma_target #(.els_p(4096)) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .io_cmd_header_i  (io_cmd_header_i),
      .io_cmd_data_i    (io_cmd_data_i),
      .io_cmd_v_i       (io_cmd_v_i),
      .io_cmd_ready_o   (io_cmd_ready_o),
      .io_resp_header_o (io_resp_header_o),
      .io_resp_data_o   (io_resp_data_o),
      .io_resp_v_o      (io_resp_v_o),
      .io_resp_yumi_i   (io_resp_yumi_i),
      .wr_count_o       (wr_count_o),
      .err_o            (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   logic [31:0] m_wr_count;
   bit          m_err;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // n bytes starting at addr, replicated to 64 bits, then across the block
   function automatic logic [511:0] exp_read(input logic [39:0] addr, input int n);
      logic [63:0] w;
      int base;
      base = int'(addr[14:0]);
      for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[(base + (k % n)) % MEM_BYTES];
      return {8{w}};
   endfunction

   // No response may be offered while a command can be accepted
   always @(negedge clk) begin
      if (reset_i === 1'b0 && io_resp_v_o === 1'b1) check("ready_excl", io_cmd_ready_o, 1'b0);
   end

   task automatic do_cmd(input bp_bedrock_mem_type_e mt, input logic [39:0] addr,
                         input logic [2:0] size, input logic [63:0] wdata,
                         input int stall, input bit abort, output logic [511:0] got);
      bp_bedrock_cce_mem_header_s h;
      logic [511:0] exp_data;
      int n, off, exp_lat, lat;
      bit is_wr, is_rd, ok;

      n     = (size > 3'd3) ? 8 : (1 << size);
      off   = int'(addr[2:0]);
      ok    = (off % n) == 0;
      is_wr = (mt == e_bedrock_mem_uc_wr);
      is_rd = (mt == e_bedrock_mem_uc_rd);
      h.msg_type = mt;
      h.subop    = 4'($urandom);
      h.addr     = addr;
      h.size     = size;
      h.payload  = 16'($urandom);

      @(negedge clk);
      check("ready_idle", io_cmd_ready_o, 1'b1);
      io_cmd_header_i = h;
      io_cmd_data_i   = {{14{$urandom}}, wdata};
      io_cmd_v_i      = 1'b1;

      if (is_wr) begin
         if (m_wr_count != 32'hFFFF_FFFF) m_wr_count++;
         if (ok) for (int i = 0; i < n; i++)
            ref_mem[(int'(addr[14:0]) + i) % MEM_BYTES] = wdata[8*i +: 8];
      end
      if (!(is_wr || is_rd) || !ok) m_err = 1'b1;
      exp_data = (is_rd && ok) ? exp_read(addr, n) : '0;
      exp_lat  = is_rd ? 2 : 1;

      @(negedge clk);
      io_cmd_v_i = 1'b0;
      lat = 1;
      while (io_resp_v_o !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, exp_lat);
      check("resp_hdr", io_resp_header_o, h);
      check("resp_data", io_resp_data_o, exp_data);
      check("wr_count", wr_count_o, m_wr_count);
      check("err", err_o, m_err);
      got = io_resp_data_o;

      if (abort) begin
         #1 reset_i = 1'b1;
         #1;
         check("rst_resp_v", io_resp_v_o, 1'b0);
         check("rst_wr_count", wr_count_o, 32'd0);
         check("rst_err", err_o, 1'b0);
         check("rst_hdr_data", {io_resp_header_o, io_resp_data_o[63:0]}, '0);
         m_wr_count = '0;
         m_err      = 1'b0;
         @(negedge clk);
         reset_i = 1'b0;
         #1;
         check("rst_rel_ready", {io_cmd_ready_o, io_resp_v_o}, 2'b10);
      end else begin
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_v_ready", {io_resp_v_o, io_cmd_ready_o}, 2'b10);
            check("stall_hold", {io_resp_header_o, io_resp_data_o[63:0]}, {h, exp_data[63:0]});
         end
         io_resp_yumi_i = 1'b1;
         @(negedge clk);
         io_resp_yumi_i = 1'b0;
      end
   endtask

   initial begin
      logic [511:0] got;
      logic [39:0]  a;
      int           r;
      bp_bedrock_mem_type_e mt;

      reset_i         = 1'b1;
      io_cmd_header_i = '0;
      io_cmd_data_i   = '0;
      io_cmd_v_i      = 1'b0;
      io_resp_yumi_i  = 1'b0;
      m_wr_count      = '0;
      m_err           = 1'b0;

      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      #1;
      check("reset_ready", io_cmd_ready_o, 1'b1);
      check("reset_resp_v", io_resp_v_o, 1'b0);
      check("reset_wr_count", wr_count_o, 32'd0);
      check("reset_err", err_o, 1'b0);
      check("reset_hdr", io_resp_header_o, '0);
      check("reset_data", io_resp_data_o, '0);

      // Directed cases
      do_cmd(e_bedrock_mem_uc_wr, 40'h10, 3'd3, 64'h1122334455667788, 0, 0, got);
      do_cmd(e_bedrock_mem_uc_rd, 40'h10, 3'd3, 64'h0, 0, 0, got);
      check("plan_rd8", got, {8{64'h1122334455667788}});
      check("plan_wr_count1", wr_count_o, 32'd1);

      do_cmd(e_bedrock_mem_uc_wr, 40'h14, 3'd2, 64'hDEADBEEF, 0, 0, got);
      do_cmd(e_bedrock_mem_uc_rd, 40'h10, 3'd3, 64'h0, 0, 0, got);
      check("plan_rd_merge", got, {8{64'hDEADBEEF55667788}});
      do_cmd(e_bedrock_mem_uc_rd, 40'h16, 3'd1, 64'h0, 0, 0, got);
      check("plan_rd2", got, {32{16'hDEAD}});
      check("plan_err_clean", err_o, 1'b0);

      do_cmd(e_bedrock_mem_uc_wr, 40'h12, 3'd2, 64'hCAFEF00D, 2, 0, got);
      check("plan_misalign_err", err_o, 1'b1);
      do_cmd(e_bedrock_mem_uc_rd, 40'h10, 3'd3, 64'h0, 0, 0, got);
      check("plan_misalign_nowr", got, {8{64'hDEADBEEF55667788}});
      check("plan_err_sticky", err_o, 1'b1);

      do_cmd(e_bedrock_mem_uc_rd, 40'h11, 3'd1, 64'h0, 0, 0, got);
      check("misalign_rd_zero", got, '0);
      do_cmd(e_bedrock_mem_uc_rd, 40'h10, 3'd6, 64'h0, 0, 0, got);
      check("big_size_as_8", got, {8{64'hDEADBEEF55667788}});
      do_cmd(e_bedrock_mem_uc_rd, 40'hA5_0000_8014, 3'd2, 64'h0, 0, 0, got);
      check("alias_rd4", got, {16{32'hDEADBEEF}});
      do_cmd(e_bedrock_mem_rd, 40'h10, 3'd3, 64'h0, 0, 0, got);
      check("unsupported_zero", got, '0);

      // Reset while a response is pending
      do_cmd(e_bedrock_mem_uc_wr, 40'h18, 3'd3, 64'h0123456789ABCDEF, 0, 1, got);

      // Accelerator-style write stream with periodic back-pressure
      for (int i = 0; i < 64; i++) begin
         do_cmd(e_bedrock_mem_uc_wr, 40'(i * 4), 3'd2, {32'($urandom), 32'($urandom)},
                (i % 7 == 6) ? 5 : 0, 0, got);
      end
      check("stream_wr_count", wr_count_o, 32'd64);

      // Random mix over the initialised region with aliasing upper bits
      for (int i = 0; i < 120; i++) begin
         a = {25'($urandom), 7'd0, 8'($urandom)};
         r = $urandom_range(0, 9);
         if (r < 4)      mt = e_bedrock_mem_uc_wr;
         else if (r < 8) mt = e_bedrock_mem_uc_rd;
         else            mt = bp_bedrock_mem_type_e'(($urandom_range(0, 3) < 2) ?
                                  $urandom_range(0, 1) : $urandom_range(4, 5));
         do_cmd(mt, a, 3'($urandom), {32'($urandom), 32'($urandom)},
                (i % 5 == 4) ? 2 : 0, 0, got);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
